// File: rtl/mc_traffic_gen_checker.sv
// Traffic generator and in-order read checker for memory_controller.
// Issues NUM_REQ writes and/or reads (addr idx*STRIDE, data idx^SEED) and checks each returned beat.
module mc_traffic_gen_checker #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned NUM_REQ    = 1023,
  parameter int unsigned STRIDE     = 1,
  parameter int unsigned SEED       = 0,
  parameter int unsigned TIMEOUT    = 200,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  out_busy,
  output logic                  in_valid,
  output logic                  in_request_type,
  output logic [ADDR_WIDTH-1:0] in_request_address,
  output logic [DATA_WIDTH-1:0] in_request_data,
  input  logic                  read_done,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  cycle_count
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]      NUM_IDX   = IDX_W'(NUM_REQ);
  localparam logic [TO_W-1:0]       TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STRIDE);
  localparam logic [DATA_WIDTH-1:0] DATA_MASK = DATA_WIDTH'(SEED);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [1:0]            mode_r;
  logic [IDX_W-1:0]      idx, checked, rd_issued;
  logic [ADDR_WIDTH-1:0] exp_addr;
  logic [TO_W-1:0]       idle_cnt;
  logic                  first_seen;

  logic                  launch, accept, last, reading, in_range, wd_armed;
  logic                  mismatch, beat_err, beat_ok, fire, chk_last;
  logic [CNT_WIDTH-1:0]  err_nx;
  logic [IDX_W-1:0]      checked_nx;
  logic                  pass_nx;

  // Handshake, checker and watchdog strobes
  always_comb begin
    launch     = start & ((state == S_IDLE) | (state == S_DONE));
    accept     = in_valid & ~out_busy;
    last       = (idx == LAST_IDX);
    reading    = (state == S_RD) | (state == S_DRAIN);
    in_range   = reading & (checked < NUM_IDX);
    beat_ok    = read_done & in_range;
    mismatch   = beat_ok & (data_out != (DATA_WIDTH'(checked) ^ DATA_MASK));
    beat_err   = read_done & (~in_range | mismatch);
    wd_armed   = reading & (rd_issued > checked);
    fire       = wd_armed & ~read_done & (idle_cnt == TO_LAST);
    chk_last   = beat_ok & (checked == LAST_IDX);
    checked_nx = checked + IDX_W'(beat_ok);
    err_nx     = err_count;
    if (beat_err && (err_count != CNT_MAX)) err_nx = err_count + CNT_WIDTH'(1);
    pass_nx    = (mode_r == 2'b01) |
                 ((err_nx == '0) & ~(timeout_err | fire) & (checked_nx == NUM_IDX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = (mode == 2'b10) ? S_RD : S_WR;
      S_WR:    if (accept && last) state_nx = (mode_r == 2'b01) ? S_DONE : S_RD;
      S_RD: begin
        if (fire)                state_nx = S_DONE;
        else if (accept && last) state_nx = S_DRAIN;
      end
      S_DRAIN: if (fire || chk_last || (checked == NUM_IDX)) state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_r             <= '0;
      idx                <= '0;
      checked            <= '0;
      rd_issued          <= '0;
      exp_addr           <= '0;
      idle_cnt           <= '0;
      first_seen         <= 1'b0;
      in_valid           <= 1'b0;
      in_request_type    <= 1'b0;
      in_request_address <= '0;
      in_request_data    <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
      pass               <= 1'b0;
      err_count          <= '0;
      first_err_addr     <= '0;
      timeout_err        <= 1'b0;
      cycle_count        <= '0;
    end else begin
      busy <= (state_nx == S_WR) | (state_nx == S_RD) | (state_nx == S_DRAIN);
      if (launch) begin
        mode_r             <= mode;
        idx                <= '0;
        checked            <= '0;
        rd_issued          <= '0;
        exp_addr           <= '0;
        idle_cnt           <= '0;
        first_seen         <= 1'b0;
        in_valid           <= 1'b1;
        in_request_type    <= (mode != 2'b10);
        in_request_address <= '0;
        in_request_data    <= DATA_MASK;
        done               <= 1'b0;
        pass               <= 1'b0;
        err_count          <= '0;
        first_err_addr     <= '0;
        timeout_err        <= 1'b0;
        cycle_count        <= '0;
      end else begin
        if (((state == S_WR) | reading) && (cycle_count != CNT_MAX))
          cycle_count <= cycle_count + CNT_WIDTH'(1);
        // Request issue; WR hands straight over to RD without a gap cycle
        if (accept && ((state == S_WR) || (state == S_RD))) begin
          if (state == S_RD) rd_issued <= rd_issued + IDX_W'(1);
          if (last) begin
            if ((state == S_WR) && (mode_r != 2'b01)) begin
              idx                <= '0;
              in_request_type    <= 1'b0;
              in_request_address <= '0;
              in_request_data    <= DATA_MASK;
            end else begin
              in_valid <= 1'b0;
            end
          end else begin
            idx                <= idx + IDX_W'(1);
            in_request_address <= in_request_address + ADDR_STEP;
            in_request_data    <= DATA_WIDTH'(idx + IDX_W'(1)) ^ DATA_MASK;
          end
        end
        if (fire) in_valid <= 1'b0;
        err_count <= err_nx;
        checked   <= checked_nx;
        if (beat_ok) exp_addr <= exp_addr + ADDR_STEP;
        if (mismatch && !first_seen) begin
          first_seen     <= 1'b1;
          first_err_addr <= exp_addr;
        end
        if (!wd_armed || read_done) idle_cnt <= '0;
        else                        idle_cnt <= idle_cnt + TO_W'(1);
        if (fire) timeout_err <= 1'b1;
        if ((state_nx == S_DONE) && (state != S_DONE)) begin
          done <= 1'b1;
          pass <= pass_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_mc_traffic_gen_checker.sv
// Directed bench for mc_traffic_gen_checker with a behavioural memory beside it.
module tb_mc_traffic_gen_checker;
  localparam int DW = 16;
  localparam int AW = 30;
  localparam int NREQ = 40;
  localparam int STRIDE = 4;
  localparam int SEED = 'hA5;
  localparam int TIMEOUT = 20;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, out_busy, read_done;
  logic [1:0]    mode;
  logic          in_valid, in_request_type, busy, done, pass, timeout_err;
  logic [AW-1:0] in_request_address, first_err_addr;
  logic [DW-1:0] in_request_data, data_out;
  logic [CW-1:0] err_count, cycle_count;

  mc_traffic_gen_checker #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NREQ), .STRIDE(STRIDE),
    .SEED(SEED), .TIMEOUT(TIMEOUT), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .out_busy(out_busy),
    .in_valid(in_valid), .in_request_type(in_request_type),
    .in_request_address(in_request_address), .in_request_data(in_request_data),
    .read_done(read_done), .data_out(data_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_addr(first_err_addr), .timeout_err(timeout_err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // memory model state and knobs
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rq[$];
  bit  busy_rand = 0, spur = 0, pend = 0;
  int  corrupt_beat = -1, drop_beat = -1;
  int  wr_acc = 0, rd_acc = 0, beat_no = 0, seq_err = 0, stab_err = 0;
  int  cyc = 0, last_cyc = 0, to_cyc = -1;
  logic          p_type;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;

  // Memory/handshake model: decides out_busy for the next edge and records that edge's accept
  initial begin
    logic [DW-1:0] d;
    out_busy = 1'b0; read_done = 1'b0; data_out = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        rq.delete(); pend = 0; read_done = 1'b0; out_busy = 1'b0;
      end else begin
        if (pend && (in_valid !== 1'b1 || in_request_type !== p_type ||
                     in_request_address !== p_addr || in_request_data !== p_data))
          stab_err++;
        if (timeout_err === 1'b1 && to_cyc < 0) to_cyc = cyc;
        read_done = 1'b0;
        if (spur) begin
          read_done = 1'b1; data_out = 16'hDEAD; spur = 0;
        end else if (rq.size() > 0) begin
          d = rq.pop_front();
          if (beat_no != drop_beat) begin
            read_done = 1'b1;
            data_out = (beat_no == corrupt_beat) ? (d ^ 16'h0001) : d;
            last_cyc = cyc;
          end
          beat_no++;
        end
        out_busy = busy_rand ? ($urandom_range(0, 1) == 1) : 1'b0;
        if (in_valid === 1'b1 && !out_busy) begin
          if (in_request_type) begin
            if (in_request_address !== AW'(wr_acc * STRIDE) ||
                in_request_data !== (DW'(wr_acc) ^ DW'(SEED))) seq_err++;
            mem[in_request_address[7:0]] = in_request_data;
            wr_acc++;
          end else begin
            if (in_request_address !== AW'(rd_acc * STRIDE)) seq_err++;
            rq.push_back(mem[in_request_address[7:0]]);
            rd_acc++;
          end
          pend = 0;
        end else begin
          pend = (in_valid === 1'b1);
          p_type = in_request_type; p_addr = in_request_address; p_data = in_request_data;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic pulse_start(input logic [1:0] m);
    @(negedge clk);
    wr_acc = 0; rd_acc = 0; beat_no = 0; seq_err = 0; stab_err = 0; to_cyc = -1;
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0; mode = m ^ 2'b11;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    n_checks++;
    if (done !== 1'b1) $display("FAIL %s_done: done=%b required 1", tag, done);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; mode = 2'b00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_valid, in_request_type, in_request_address, in_request_data, busy, done, pass,
         err_count, first_err_addr, timeout_err, cycle_count} !== '0)
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b err=%0d cyc=%0d required all 0",
               in_valid, busy, done, err_count, cycle_count);
    else n_pass++;
    rst_n = 1'b1;
    spur = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_count !== 1 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL idle_spurious: err=%0d busy=%b done=%b required 1/0/0", err_count, busy, done);
    else n_pass++;
  endtask

  task automatic test_mode00;
    busy_rand = 0; corrupt_beat = -1; drop_beat = -1;
    pulse_start(2'b00);
    n_checks++;
    if ({in_valid, in_request_type, busy} !== 3'b111 || in_request_address !== '0 ||
        in_request_data !== DW'(SEED) || err_count !== 0)
      $display("FAIL first_req: v=%b t=%b busy=%b a=%0h d=%0h err=%0d required 1/1/1/0/a5/0",
               in_valid, in_request_type, busy, in_request_address, in_request_data, err_count);
    else n_pass++;
    wait_done("mode00");
    n_checks++;
    if (pass !== 1'b1 || err_count !== 0 || timeout_err !== 1'b0 || busy !== 1'b0)
      $display("FAIL mode00_status: pass=%b err=%0d to=%b busy=%b required 1/0/0/0",
               pass, err_count, timeout_err, busy);
    else n_pass++;
    n_checks++;
    if (wr_acc !== NREQ || rd_acc !== NREQ || seq_err !== 0 || beat_no !== NREQ)
      $display("FAIL mode00_traffic: wr=%0d rd=%0d seq=%0d beats=%0d required 40/40/0/40",
               wr_acc, rd_acc, seq_err, beat_no);
    else n_pass++;
    n_checks++;
    if (cycle_count !== 2 * NREQ + 1)
      $display("FAIL mode00_cycles: cycle_count=%0d required %0d", cycle_count, 2 * NREQ + 1);
    else n_pass++;
  endtask

  task automatic test_busy_random;
    busy_rand = 1;
    pulse_start(2'b11);
    wait_done("busy_rand");
    busy_rand = 0;
    n_checks++;
    if (wr_acc !== NREQ || rd_acc !== NREQ || seq_err !== 0 || stab_err !== 0)
      $display("FAIL busy_traffic: wr=%0d rd=%0d seq=%0d stab=%0d required 40/40/0/0",
               wr_acc, rd_acc, seq_err, stab_err);
    else n_pass++;
    n_checks++;
    if (pass !== 1'b1 || err_count !== 0)
      $display("FAIL busy_status: pass=%b err=%0d required 1/0", pass, err_count);
    else n_pass++;
  endtask

  task automatic test_corrupt;
    corrupt_beat = 5;
    pulse_start(2'b00);
    wait_done("corrupt");
    corrupt_beat = -1;
    n_checks++;
    if (err_count !== 1 || first_err_addr !== 30'd20 || pass !== 1'b0 || timeout_err !== 1'b0)
      $display("FAIL corrupt_status: err=%0d first=%0d pass=%b to=%b required 1/20/0/0",
               err_count, first_err_addr, pass, timeout_err);
    else n_pass++;
  endtask

  task automatic test_drop;
    drop_beat = NREQ - 1;
    pulse_start(2'b00);
    wait_done("drop");
    drop_beat = -1;
    n_checks++;
    if (timeout_err !== 1'b1 || pass !== 1'b0 || err_count !== 0)
      $display("FAIL drop_status: to=%b pass=%b err=%0d required 1/0/0", timeout_err, pass, err_count);
    else n_pass++;
    // last beat sampled on the edge after negedge last_cyc; flag seen one negedge after edge TIMEOUT
    n_checks++;
    if (to_cyc - last_cyc !== TIMEOUT + 1)
      $display("FAIL drop_latency: delta=%0d required %0d", to_cyc - last_cyc, TIMEOUT + 1);
    else n_pass++;
  endtask

  task automatic test_reset_midrun;
    pulse_start(2'b00);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({in_valid, in_request_type, in_request_address, in_request_data, busy, done, pass,
         err_count, first_err_addr, timeout_err, cycle_count} !== '0)
      $display("FAIL midrun_reset: valid=%b busy=%b done=%b cyc=%0d required all 0",
               in_valid, busy, done, cycle_count);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL post_reset_idle: valid=%b busy=%b required 0/0", in_valid, busy);
    else n_pass++;
    pulse_start(2'b10);
    n_checks++;
    if (in_valid !== 1'b1 || in_request_type !== 1'b0 || in_request_address !== '0)
      $display("FAIL rd_first_req: v=%b t=%b a=%0h required 1/0/0",
               in_valid, in_request_type, in_request_address);
    else n_pass++;
    wait_done("rd_only");
    n_checks++;
    if (pass !== 1'b1 || wr_acc !== 0 || rd_acc !== NREQ || seq_err !== 0 || err_count !== 0)
      $display("FAIL rd_only_status: pass=%b wr=%0d rd=%0d seq=%0d err=%0d required 1/0/40/0/0",
               pass, wr_acc, rd_acc, seq_err, err_count);
    else n_pass++;
  endtask

  task automatic test_spurious;
    pulse_start(2'b00);
    repeat (3) @(negedge clk);
    spur = 1;
    repeat (4) @(negedge clk);
    start = 1'b1; mode = 2'b10;
    @(negedge clk);
    start = 1'b0;
    wait_done("spurious");
    n_checks++;
    if (err_count !== 1 || pass !== 1'b0 || wr_acc !== NREQ || rd_acc !== NREQ)
      $display("FAIL spurious_status: err=%0d pass=%b wr=%0d rd=%0d required 1/0/40/40",
               err_count, pass, wr_acc, rd_acc);
    else n_pass++;
    spur = 1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (err_count !== 2 || done !== 1'b1 || pass !== 1'b0)
      $display("FAIL done_spurious: err=%0d done=%b pass=%b required 2/1/0", err_count, done, pass);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    pulse_start(2'b01);
    n_checks++;
    if (done !== 1'b0 || err_count !== 0 || busy !== 1'b1)
      $display("FAIL restart_clear: done=%b err=%0d busy=%b required 0/0/1", done, err_count, busy);
    else n_pass++;
    wait_done("wr_only");
    n_checks++;
    if (pass !== 1'b1 || wr_acc !== NREQ || rd_acc !== 0 || cycle_count !== NREQ || in_valid !== 1'b0)
      $display("FAIL wr_only_status: pass=%b wr=%0d rd=%0d cyc=%0d v=%b required 1/40/0/40/0",
               pass, wr_acc, rd_acc, cycle_count, in_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_mode00();
    test_busy_random();
    test_corrupt();
    test_drop();
    test_reset_midrun();
    test_spurious();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
